// File: rtl/nbody_hls_deadlock_report_ctrl.sv
// Supervises the per-process deadlock detect units: confirms a detect, picks an origin
// round-robin, traces the token around the wait cycle and records confirmed reports.
//
// state   | meaning
// IDLE    | no detect seen
// CONFIRM | detect must persist CONFIRM_CYCLES consecutive cycles
// ARB     | round-robin pick of one detecting process
// ORIGIN  | one-cycle origin strobe to the picked unit
// TRACE   | waiting for the token to come back, abort or timeout
// REPORT  | token_clear pulse, report recorded
// HOLD    | wait for all detects to drop before re-arming
module nbody_hls_deadlock_report_ctrl #(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_ret_vec,
    input  logic                report_ack,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                deadlock_flag,
    output logic [PROC_NUM-1:0] deadlock_proc,
    output logic [CNT_W-1:0]    deadlock_cnt
);
    localparam int IDX_W = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
    localparam int CC_W  = $clog2(CONFIRM_CYCLES + 1);
    localparam int TC_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CC_W-1:0] CONF_LAST = CC_W'(CONFIRM_CYCLES - 1);
    localparam logic [TC_W-1:0] TO_LAST   = TC_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIRM, S_ARB, S_ORIGIN, S_TRACE, S_REPORT, S_HOLD
    } state_t;

    state_t              state, state_nx;
    logic [CC_W-1:0]     conf_cnt;
    logic [TC_W-1:0]     to_cnt;
    logic [PROC_NUM-1:0] sel;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    last_idx;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_found;
    logic [PROC_NUM-1:0] grant_onehot;
    logic                any_detect, sel_alive, token_back;

    logic [PROC_NUM-1:0] origin_d;
    logic                token_clear_d;
    logic                flag_d;
    logic [PROC_NUM-1:0] proc_d;
    logic [CNT_W-1:0]    cnt_d;

    assign any_detect   = |dl_detect_vec;
    assign sel_alive    = |(dl_detect_vec & sel);
    assign token_back   = |(token_ret_vec & sel);
    assign grant_onehot = PROC_NUM'(1) << grant_idx;

    // Scan starts one past the last reported process and wraps.
    always_comb begin : rr_scan
        int idx;
        idx         = 0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int i = 1; i <= PROC_NUM; i++) begin
            idx = int'(last_idx) + i;
            if (idx >= PROC_NUM) idx = idx - PROC_NUM;
            if (!grant_found && dl_detect_vec[IDX_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (any_detect) state_nx = S_CONFIRM;
            S_CONFIRM: begin
                if (!any_detect)               state_nx = S_IDLE;
                else if (conf_cnt == CONF_LAST) state_nx = S_ARB;
            end
            S_ARB:     state_nx = grant_found ? S_ORIGIN : S_IDLE;
            S_ORIGIN:  state_nx = S_TRACE;
            S_TRACE: begin
                if (token_back)            state_nx = S_REPORT;
                else if (!sel_alive)       state_nx = S_IDLE;
                else if (to_cnt == TO_LAST) state_nx = S_IDLE;
            end
            S_REPORT:  state_nx = S_HOLD;
            S_HOLD:    if (!any_detect) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; a report is recorded on entry to REPORT.
    always_comb begin
        origin_d      = (state == S_ARB && grant_found) ? grant_onehot : '0;
        token_clear_d = (state == S_TRACE) && token_back;
        flag_d        = deadlock_flag;
        proc_d        = deadlock_proc;
        cnt_d         = deadlock_cnt;
        if (token_clear_d) begin
            flag_d = 1'b1;
            proc_d = sel;
            if (deadlock_cnt != '1) cnt_d = deadlock_cnt + 1'b1;
        end else if (report_ack && state != S_REPORT) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            origin        <= '0;
            token_clear   <= 1'b0;
            deadlock_flag <= 1'b0;
            deadlock_proc <= '0;
            deadlock_cnt  <= '0;
            conf_cnt      <= '0;
            to_cnt        <= '0;
            sel           <= '0;
            sel_idx       <= '0;
            last_idx      <= IDX_W'(PROC_NUM - 1);
        end else begin
            origin        <= origin_d;
            token_clear   <= token_clear_d;
            deadlock_flag <= flag_d;
            deadlock_proc <= proc_d;
            deadlock_cnt  <= cnt_d;
            conf_cnt      <= (state == S_CONFIRM) ? conf_cnt + 1'b1 : '0;
            to_cnt        <= (state == S_TRACE) ? to_cnt + 1'b1 : '0;
            if (state == S_ARB && grant_found) begin
                sel     <= grant_onehot;
                sel_idx <= grant_idx;
            end
            if (state == S_REPORT) last_idx <= sel_idx;
        end
    end
endmodule

// File: tb/tb_nbody_hls_deadlock_report_ctrl.sv
// Scoreboard bench: stimulus queues expected origin strobes and reports, a negedge
// monitor pops and compares whenever origin or token_clear is presented.
module tb_nbody_hls_deadlock_report_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] dl_detect_vec = '0;
    logic [3:0] token_ret_vec = '0;
    logic       report_ack = 1'b0;
    logic [3:0] origin;
    logic       token_clear;
    logic       deadlock_flag;
    logic [3:0] deadlock_proc;
    logic [1:0] deadlock_cnt;

    nbody_hls_deadlock_report_ctrl #(
        .PROC_NUM(4), .CONFIRM_CYCLES(8), .TIMEOUT_CYCLES(64), .CNT_W(2)
    ) dut (
        .clock(clock), .reset(reset), .dl_detect_vec(dl_detect_vec),
        .token_ret_vec(token_ret_vec), .report_ack(report_ack), .origin(origin),
        .token_clear(token_clear), .deadlock_flag(deadlock_flag),
        .deadlock_proc(deadlock_proc), .deadlock_cnt(deadlock_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] proc;
        logic [1:0] cnt;
    } rep_t;

    logic [3:0] exp_origin_q[$];
    rep_t       exp_rep_q[$];
    rep_t       e;
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tc_cyc   = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (origin != 4'b0000) begin
                check("origin_onehot", 32'($onehot(origin)), 32'd1);
                if (exp_origin_q.size() == 0) check("origin_unexpected", 32'(origin), 32'd0);
                else check("origin_sel", 32'(origin), 32'(exp_origin_q.pop_front()));
            end
            if (token_clear) begin
                tc_cyc = cyc;
                check("clear_excl_origin", 32'(origin), 32'd0);
                if (exp_rep_q.size() == 0) begin
                    check("report_unexpected", 32'(token_clear), 32'd0);
                end else begin
                    e = exp_rep_q.pop_front();
                    check("report_proc", 32'(deadlock_proc), 32'(e.proc));
                    check("report_cnt", 32'(deadlock_cnt), 32'(e.cnt));
                    check("report_flag", 32'(deadlock_flag), 32'd1);
                end
            end
        end
    end

    task automatic wait_origin(input int max_cyc);
        int k;
        k = 0;
        while (origin == 4'b0000 && k < max_cyc) begin
            @(negedge clock);
            k++;
        end
        if (origin == 4'b0000) begin
            n_checks++;
            $display("FAIL origin_wait: no origin within %0d cycles", max_cyc);
        end
    endtask

    // Full detect -> report sequence with token returned the cycle after origin.
    task automatic run_report(input logic [3:0] det, input logic [3:0] ret,
                              input logic [3:0] exp_sel, input logic [1:0] exp_cnt,
                              input bit ack_in_report);
        int t0;
        exp_origin_q.push_back(exp_sel);
        exp_rep_q.push_back('{proc: exp_sel, cnt: exp_cnt});
        dl_detect_vec = det;
        t0 = cyc;
        wait_origin(30);
        @(posedge clock); #1 token_ret_vec = ret;
        @(posedge clock); #1 token_ret_vec = '0;
        if (ack_in_report) report_ack = 1'b1;
        @(posedge clock); #1;
        check("flag_after_report", 32'(deadlock_flag), 32'd1);
        check("latency", 32'(tc_cyc - t0), 32'd12);
        if (ack_in_report) begin
            @(posedge clock); #1 report_ack = 1'b0;
            check("flag_ack_after_report", 32'(deadlock_flag), 32'd0);
        end
        dl_detect_vec = '0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1;
        #2;
        check("rst_origin", 32'(origin), 32'd0);
        check("rst_token_clear", 32'(token_clear), 32'd0);
        check("rst_flag", 32'(deadlock_flag), 32'd0);
        check("rst_proc", 32'(deadlock_proc), 32'd0);
        check("rst_cnt", 32'(deadlock_cnt), 32'd0);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;

        // short detect never reaches arbitration
        dl_detect_vec = 4'b0001;
        repeat (5) @(posedge clock);
        #1 dl_detect_vec = '0;
        repeat (20) @(posedge clock);
        #1;
        check("short_cnt", 32'(deadlock_cnt), 32'd0);
        check("short_flag", 32'(deadlock_flag), 32'd0);

        run_report(4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b0);
        report_ack = 1'b1;
        @(posedge clock); #1 report_ack = 1'b0;
        check("ack_flag", 32'(deadlock_flag), 32'd0);
        check("ack_cnt_hold", 32'(deadlock_cnt), 32'd1);
        check("ack_proc_hold", 32'(deadlock_proc), 32'h2);

        run_report(4'b0110, 4'b0100, 4'b0100, 2'd2, 1'b0);

        // no token return: timeout, then the same process is picked again
        exp_origin_q.push_back(4'b0010);
        exp_origin_q.push_back(4'b0010);
        exp_rep_q.push_back('{proc: 4'b0010, cnt: 2'd3});
        dl_detect_vec = 4'b0110;
        wait_origin(30);
        t1 = cyc;
        @(posedge clock); #1;
        wait_origin(120);
        check("timeout_gap", 32'(cyc - t1), 32'd75);
        check("timeout_flag", 32'(deadlock_flag), 32'd1);
        check("timeout_cnt", 32'(deadlock_cnt), 32'd2);
        @(posedge clock); #1 token_ret_vec = 4'b0010;
        @(posedge clock); #1 token_ret_vec = '0;
        @(posedge clock); #1 dl_detect_vec = '0;
        repeat (3) @(posedge clock);
        #1 report_ack = 1'b1;
        @(posedge clock); #1 report_ack = 1'b0;
        check("pre_ack_flag", 32'(deadlock_flag), 32'd0);

        run_report(4'b0110, 4'b0100, 4'b0100, 2'd3, 1'b1);
        run_report(4'b0110, 4'b0010, 4'b0010, 2'd3, 1'b0);

        // abort: detect drops during trace
        exp_origin_q.push_back(4'b1000);
        dl_detect_vec = 4'b1000;
        wait_origin(30);
        @(posedge clock); #1 dl_detect_vec = '0;
        repeat (5) @(posedge clock);
        #1;
        check("abort_cnt", 32'(deadlock_cnt), 32'd3);
        check("abort_proc", 32'(deadlock_proc), 32'h2);

        run_report(4'b1010, 4'b1000, 4'b1000, 2'd3, 1'b0);
        run_report(4'b0001, 4'b0001, 4'b0001, 2'd3, 1'b0);

        // reset in the middle of a trace
        exp_origin_q.push_back(4'b0010);
        dl_detect_vec = 4'b0011;
        wait_origin(30);
        @(posedge clock); #1 reset = 1'b0;
        #1;
        check("midrst_origin", 32'(origin), 32'd0);
        check("midrst_token_clear", 32'(token_clear), 32'd0);
        check("midrst_flag", 32'(deadlock_flag), 32'd0);
        check("midrst_proc", 32'(deadlock_proc), 32'd0);
        check("midrst_cnt", 32'(deadlock_cnt), 32'd0);
        dl_detect_vec = '0;
        @(posedge clock); #1 reset = 1'b1;
        run_report(4'b0011, 4'b0001, 4'b0001, 2'd1, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("origin_q_empty", 32'(exp_origin_q.size()), 32'd0);
        check("report_q_empty", 32'(exp_rep_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nbody_hls_deadlock_report_ctrl.md
NBODY_HLS_DEADLOCK_REPORT_CTRL -- requirements
Module: nbody_hls_deadlock_report_ctrl

Interface
REQ-001 Parameter PROC_NUM, default 4: number of dataflow processes (deadlock detect units) supervised; range 2..32.
REQ-002 Parameter CONFIRM_CYCLES, default 8: consecutive cycles any detect must persist before arbitration; range ≥1.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: maximum TRACE cycles waiting for token return; range ≥2.
REQ-004 Parameter CNT_W, default 8: width of saturating report counter.
REQ-005 reset  input  1  asynchronous, active-low.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 dl_detect_vec  input  PROC_NUM  per-process dl_detect_out from the detect units.
REQ-008 token_ret_vec  input  PROC_NUM  per-process "token arrived back at this process" indication.
REQ-009 report_ack  input  1  software/host acknowledge; clears deadlock_flag.
REQ-010 origin  output  PROC_NUM  one-hot origin strobe to the selected detect unit.
REQ-011 token_clear  output  1  one-cycle pulse broadcast to all detect units.
REQ-012 deadlock_flag  output  1  sticky confirmed-deadlock indication.
REQ-013 deadlock_proc  output  PROC_NUM  one-hot ID of the process that closed the confirmed cycle.
REQ-014 deadlock_cnt  output  CNT_W  number of confirmed reports, saturating.

Function
REQ-015 All outputs SHALL be registered; FSM states IDLE, CONFIRM, ARB, ORIGIN, TRACE, REPORT, HOLD.
REQ-016 IDLE: |dl_detect_vec -> CONFIRM with confirm counter cleared; otherwise stay.
REQ-017 CONFIRM: dl_detect_vec==0 -> IDLE; else counter increments; after CONFIRM_CYCLES consecutive cycles with |dl_detect_vec -> ARB.
REQ-018 ARB: round-robin grant = first set bit of dl_detect_vec scanning from (last_grant+1) mod PROC_NUM upward with wrap; latch one-hot sel; -> ORIGIN; dl_detect_vec==0 in ARB -> IDLE, no grant.
REQ-019 ORIGIN: origin = sel for exactly one cycle, zero in every other state; -> TRACE with timeout counter cleared.
REQ-020 TRACE: |(token_ret_vec & sel) -> REPORT; (dl_detect_vec & sel)==0 -> IDLE (abort); timeout counter reaching TIMEOUT_CYCLES-1 -> IDLE (false alarm); token return takes priority over abort and timeout in the same cycle.
REQ-021 REPORT: token_clear=1 for exactly one cycle; deadlock_flag<=1; deadlock_proc<=sel; deadlock_cnt increments unless all-ones; last_grant<=sel; -> HOLD.
REQ-022 HOLD: stay until dl_detect_vec==0, then -> IDLE; no new arbitration while in HOLD.
REQ-023 deadlock_flag SHALL clear on report_ack when not in REPORT; report_ack coincident with REPORT: flag stays set (set wins).
REQ-024 deadlock_proc and deadlock_cnt SHALL hold between reports and are unaffected by report_ack.
REQ-025 Aborted or timed-out traces SHALL NOT update last_grant, deadlock_proc or deadlock_cnt.
REQ-026 Minimum latency first detect -> token_clear: CONFIRM_CYCLES + 4 cycles with immediate token return.
REQ-027 origin SHALL never have more than one bit set; token_clear and origin never asserted together.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, origin=0, token_clear=0, deadlock_flag=0, deadlock_proc=0, deadlock_cnt=0, counters=0, last_grant=PROC_NUM-1 (first grant scans from bit 0).
REQ-029 reset asserted mid-TRACE or mid-REPORT SHALL drop origin/token_clear within the same cycle, no partial report recorded.

Verification
REQ-030 PROC_NUM=4, CONFIRM_CYCLES=8: dl_detect_vec=4'b0110 held, token_ret_vec=4'b0010 one cycle after origin -> origin=4'b0010 one cycle, token_clear pulse, deadlock_flag=1, deadlock_proc=4'b0010, deadlock_cnt=1.
REQ-031 dl_detect_vec=4'b0001 for 5 cycles then 0 -> returns IDLE, origin never asserted, deadlock_cnt=0.
REQ-032 After REQ-030, detects cleared then 4'b0110 reasserted -> second grant origin=4'b0100 (round-robin), deadlock_cnt=2.
REQ-033 TIMEOUT_CYCLES=64, no token return -> IDLE after 64 TRACE cycles, deadlock_flag unchanged, re-arbitrates same sel after new CONFIRM.
REQ-034 report_ack in REPORT cycle -> flag stays 1; report_ack next cycle -> flag 0; CNT_W=2 after 5 reports -> deadlock_cnt=3.
REQ-035 reset pulsed low during TRACE -> all outputs 0 immediately; after release, first grant starts scanning at bit 0.
